// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the AXI-stream FIFO: depth legality check and pointer width.
package axis_fifo_pkg;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // One extra MSB beyond the address bits acts as the wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous (fall-through) read.
// Latency: write visible on rd_dat after the writing edge; read is combinational.
// Backpressure: none; the caller gates wr_en.
module axis_fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/axis_fifo_tlast.sv
// AXI-stream FIFO (tdata+tlast), first-word-fall-through, 1-cycle write-to-read latency.
// Backpressure: s_tready = !full (registered state only); define AXIS_FIFO_PACKET_MODE_EN
// to hold m_tvalid until a complete packet is stored (or the FIFO is full).
module axis_fifo_tlast
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_THRESH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  generate
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("axis_fifo_tlast: DEPTH must be a power of two and >= 2");
    end
    if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_thresh
      $error("axis_fifo_tlast: ALMOST_FULL_THRESH must be in 1..DEPTH");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
      $error("axis_fifo_tlast: DATA_WIDTH must be >= 1");
    end
  endgenerate

  logic [PW-1:0] wptr, rptr, count_q;
  logic          rdy_en, empty, full, wr, rd;
  entry_t        wr_ent, rd_ent;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // rdy_en keeps s_tready low through reset and until the first edge after release.
  assign s_tready = rdy_en && !full;
  assign wr       = s_tvalid && s_tready;
  assign rd       = m_tvalid && m_tready;

  assign wr_ent.last = s_tlast;
  assign wr_ent.data = s_tdata;

  axis_fifo_ram #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr),
    .wr_addr (wptr[AW-1:0]),
    .wr_dat  (wr_ent),
    .rd_addr (rptr[AW-1:0]),
    .rd_dat  (rd_ent)
  );

  assign m_tdata = rd_ent.data;
  assign m_tlast = rd_ent.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      rdy_en  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (wr) wptr <= wptr + PW'(1);
      if (rd) rptr <= rptr + PW'(1);
      case ({wr, rd})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count       = count_q;
  assign almost_full = (count_q >= PW'(ALMOST_FULL_THRESH));

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [PW-1:0] pkt_cnt;
  logic          pkt_in, pkt_out;

  assign pkt_in  = wr && s_tlast;
  assign pkt_out = rd && m_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else begin
      case ({pkt_in, pkt_out})
        2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // The full override lets packets longer than DEPTH drain cut-through instead of deadlocking.
  assign m_tvalid = !empty && ((pkt_cnt != '0) || full);
`else
  assign m_tvalid = !empty;
`endif

endmodule

// File: tb/tb_axis_fifo_tlast.sv
// Randomised bench for axis_fifo_tlast against a queue-based reference model.
module tb_axis_fifo_tlast;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF_TH = DEPTH - 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b0;
  logic [4:0]    count;
  logic          almost_full;

  int n_tests = 0;
  int n_fail  = 0;
  int n_dut_rd = 0;

  logic [8:0] model_q[$];  // {last, data}
  bit         rst_ok = 1'b0;

  always #5 clk = ~clk;

  axis_fifo_tlast #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .count       (count),
    .almost_full (almost_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output is presentable when anything is stored; in packet mode only once a
  // whole packet is inside or the FIFO cannot accept more.
  function automatic bit exp_vld();
    if (model_q.size() == 0) return 1'b0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    if (model_q.size() == DEPTH) return 1'b1;
    foreach (model_q[i]) if (model_q[i][8]) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  // Entered at a negedge: drive, compare against the model, advance one clock.
  task automatic cycle(input logic sv, input logic [7:0] sd, input logic sl, input logic mr);
    bit         e_v, e_r, wr, rd;
    logic [8:0] head;
    s_tvalid = sv;
    s_tdata  = sd;
    s_tlast  = sl;
    m_tready = mr;
    #1;
    e_v = exp_vld();
    e_r = rst_ok && (model_q.size() < DEPTH);
    check("s_tready", s_tready, e_r);
    check("m_tvalid", m_tvalid, e_v);
    check("count", count, model_q.size());
    check("almost_full", almost_full, model_q.size() >= AF_TH);
    if (e_v) begin
      head = model_q[0];
      check("m_tdata", m_tdata, head[7:0]);
      check("m_tlast", m_tlast, head[8]);
    end
    if (m_tvalid && m_tready) n_dut_rd++;
    wr = sv && e_r;
    rd = mr && e_v;
    @(posedge clk);
    if (rd) void'(model_q.pop_front());
    if (wr) model_q.push_back({sl, sd});
    if (rst_n) rst_ok = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (model_q.size() > 0 && n < 200) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      n++;
    end
    check(tag, model_q.size(), 0);
  endtask

  initial begin
    int         sent;
    int         cyc;
    logic       sv, l, mr;
    logic [7:0] d;

    repeat (2) @(negedge clk);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_count", count, 0);
    check("rst_almost_full", almost_full, 1'b0);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);  // s_tready still low before the first edge

    // Single word, one-cycle latency, then read it back out.
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    check("t1_latency_vld", m_tvalid, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full with the consumer stalled; the 17th word must be refused.
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    check("t2_full_count", count, DEPTH);
    check("t2_full_ready", s_tready, 1'b0);

    // Full-rate streaming from full across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(8'h10 + i), (i % 5) == 4, 1'b1);
      check("t3_level", count >= 5'd15, 1'b1);
    end
    drain("t3_drain");

    // Random traffic with random backpressure.
    sent = 0;
    cyc  = 0;
    while ((sent < 1000 || model_q.size() > 0) && cyc < 10000) begin
      sv = (sent < 1000) && ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      l  = (sent == 999) ? 1'b1 : ($urandom_range(0, 3) == 0);
      mr = 1'($urandom_range(0, 1));
      if (sv && model_q.size() < DEPTH) sent++;
      cycle(sv, d, l, mr);
      cyc++;
    end
    check("t4_done", (sent == 1000) && (model_q.size() == 0), 1'b1);

    // Asynchronous reset mid-packet.
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    check("t5_pre_count", count, 7);
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    #1;
    check("t5_rst_count", count, 0);
    check("t5_rst_vld", m_tvalid, 1'b0);
    check("t5_rst_rdy", s_tready, 1'b0);
    model_q.delete();
    rst_ok = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("t5_post_rdy", s_tready, 1'b1);
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // Store-and-forward: nothing visible until the packet's last word lands.
    cycle(1'b1, 8'h01, 1'b0, 1'b1);
    cycle(1'b1, 8'h02, 1'b0, 1'b1);
    check("t6_hold", m_tvalid, 1'b0);
    cycle(1'b1, 8'h03, 1'b1, 1'b1);
    check("t6_release", m_tvalid, 1'b1);
    drain("t6_drain");

    // Oversized packet releases on full and streams through.
    n_dut_rd = 0;
    sent = 0;
    cyc  = 0;
    while ((sent < 20 || model_q.size() > 0) && cyc < 300) begin
      sv = (sent < 20);
      d  = 8'(8'h80 + sent);
      l  = (sent == 19);
      if (sv && model_q.size() < DEPTH) sent++;
      cycle(sv, d, l, 1'b1);
      cyc++;
    end
    check("t6_long_words", n_dut_rd, 20);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
